// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the 64-bit LEGv8 datapath.
// It owns the PC, runs the req/ready handshake to instruction memory, applies
// branch redirects (target = base + offset*4) and hands each fetched word to
// decode over a valid/ready interface. Any fetch made stale by a redirect is squashed.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   imem_req/addr     fetch request and word-aligned byte address (outputs)
//   imem_ready/rdata  memory accept and the returned instruction word
//   out_valid/instr/pc  instruction handed to decode (outputs)
//   out_ready         decode accepts the instruction
//   redirect_*        taken-branch redirect: valid, branch PC, word offset
module fetch_sequencer #(
  parameter int unsigned    N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_instr,
  output logic [N-1:0] out_pc,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_base,
  input  logic [N-1:0] redirect_offset
);

  localparam int unsigned IW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pc_q, pc_d;
  logic [N-1:0]    pend_q, pend_d;
  logic            squash_q, squash_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [N-1:0]    opc_q, opc_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    target;

  // Shifting in N-bit context drops offset bits [N-1:N-2]; the sum wraps mod 2^N.
  assign target = redirect_base + (redirect_offset << 2);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      squash_q <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      squash_q <= squash_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    squash_d = squash_q;
    instr_d  = instr_q;
    opc_d    = opc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = target;
      end
      REQ: begin
        if (imem_ready) begin
          if (squash_q || redirect_valid) begin
            // Stale word: drop it and refetch at the newest target.
            pc_d     = redirect_valid ? target : pend_q;
            squash_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            opc_d   = pc_q;
            pc_d    = pc_q + N'(4);
            state_d = OUT;
          end
        end else if (redirect_valid) begin
          // Request cannot be withdrawn; remember target and squash its data.
          pend_d   = target;
          squash_d = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = REQ;
        end else if (out_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state.
  assign req_d   = (state_d == REQ);
  assign valid_d = (state_d == OUT);

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: reset, sequential fetch, backpressure,
// redirects in OUT / REQ (with squash), address wrap and reset mid-handshake.
module tb_fetch_sequencer;

  localparam int unsigned N = 64;
  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ready;
  logic [31:0]  imem_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_instr;
  logic [N-1:0] out_pc;
  logic         redirect_valid;
  logic [N-1:0] redirect_base;
  logic [N-1:0] redirect_offset;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Memory returns a word tagged with the low address bits.
  assign imem_rdata = TAG | imem_addr[31:0];

  fetch_sequencer #(.N(N), .RESET_PC(64'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_base   (redirect_base),
    .redirect_offset (redirect_offset)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic redir(input logic [63:0] base, input logic [63:0] off);
    redirect_valid  = 1'b1;
    redirect_base   = base;
    redirect_offset = off;
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_base = '0; redirect_offset = '0;
    #2;
    step();
    check("rst_req",   64'(imem_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr",  imem_addr, 64'h0);
    check("rst_instr", 64'(out_instr), 64'h0);
    check("rst_opc",   out_pc, 64'h0);

    // Sequential fetch, zero-wait memory, decode always ready.
    reset = 1'b1; imem_ready = 1'b1; out_ready = 1'b1;
    step();
    check("first_req",  64'(imem_req), 64'd1);
    check("first_addr", imem_addr, 64'h0);
    check("first_nv",   64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("seq_valid", 64'(out_valid), 64'd1);
      check("seq_noreq", 64'(imem_req), 64'd0);
      check("seq_opc",   out_pc, 64'(4 * i));
      check("seq_instr", 64'(out_instr), 64'(TAG | 32'(4 * i)));
      if (i < 2) begin
        step();
        check("seq_req",  64'(imem_req), 64'd1);
        check("seq_nv",   64'(out_valid), 64'd0);
        check("seq_addr", imem_addr, 64'(4 * (i + 1)));
      end
    end

    // Backpressure for 5 cycles while holding word at 0x8.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_opc",   out_pc, 64'h8);
      check("bp_instr", 64'(out_instr), 64'hC0DE_0008);
      check("bp_noreq", 64'(imem_req), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_rel_req",  64'(imem_req), 64'd1);
    check("bp_rel_addr", imem_addr, 64'hC);
    step();
    check("c_opc", out_pc, 64'hC);

    // Redirect while in OUT: base 0x100, offset -2 -> 0xF8.
    redir(64'h100, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    redirect_valid = 1'b0;
    check("rdo_nv",   64'(out_valid), 64'd0);
    check("rdo_req",  64'(imem_req), 64'd1);
    check("rdo_addr", imem_addr, 64'hF8);

    // Redirect in REQ with memory stalled: base 0x40, offset 3 -> 0x4C.
    imem_ready = 1'b0;
    redir(64'h40, 64'h3);
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("sq_hold_addr", imem_addr, 64'hF8);
      check("sq_hold_req",  64'(imem_req), 64'd1);
      step();
    end
    check("sq_hold_addr3", imem_addr, 64'hF8);
    imem_ready = 1'b1;
    step();
    check("sq_drop_nv",   64'(out_valid), 64'd0);
    check("sq_drop_req",  64'(imem_req), 64'd1);
    check("sq_drop_addr", imem_addr, 64'h4C);
    step();
    check("sq_out_valid", 64'(out_valid), 64'd1);
    check("sq_out_opc",   out_pc, 64'h4C);
    check("sq_out_instr", 64'(out_instr), 64'hC0DE_004C);

    // Wrap: redirect to the last word, sequential next address is 0.
    redir(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    step();
    redirect_valid = 1'b0;
    check("wr_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wr_opc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wr_req",  64'(imem_req), 64'd1);
    check("wr_next", imem_addr, 64'h0);

    // Redirect in REQ with ready: offset top bits discarded -> target 0x4.
    redir(64'h0, 64'h4000_0000_0000_0001);
    step();
    redirect_valid = 1'b0;
    check("tr_nv",   64'(out_valid), 64'd0);
    check("tr_addr", imem_addr, 64'h4);
    check("tr_hold", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Later redirect while squash pending overwrites the pending target.
    imem_ready = 1'b0;
    redir(64'h200, 64'h0);
    step();
    redir(64'h300, 64'h0);
    step();
    redirect_valid = 1'b0;
    check("ow_hold", imem_addr, 64'h4);
    imem_ready = 1'b1;
    step();
    check("ow_nv",   64'(out_valid), 64'd0);
    check("ow_addr", imem_addr, 64'h300);

    // Reset in the middle of a stalled request.
    imem_ready = 1'b0;
    step();
    check("mr_req_pre", 64'(imem_req), 64'd1);
    reset = 1'b0;
    step();
    check("mr_req",   64'(imem_req), 64'd0);
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_addr",  imem_addr, 64'h0);
    check("mr_opc",   out_pc, 64'h0);
    check("mr_instr", 64'(out_instr), 64'h0);
    reset = 1'b1;
    step();
    check("mr_rel_req",  64'(imem_req), 64'd1);
    check("mr_rel_addr", imem_addr, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
